button_pulse: RTL and testbench
===============================

# button_pulse

Input conditioning stage in front of the directional-code detector: synchronizes, debounces and one-shots the four raw push-buttons (up, down, left, right). It emits exactly one single-cycle pulse per physical press on the matching output. A press-lockout FSM guarantees at most one direction pulse per press-and-release cycle, so a held button can never advance the detector more than one step.

## Interface
- DB_CYCLES, 500000, consecutive cycles a synchronized input must differ from the stable level before the stable level flips (5 ms at 100 MHz); legal range ≥ 2
- CNT_W, $clog2(DB_CYCLES), debounce counter width; derived, not overridden
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, one synchronous active-high reset (fixed)
- btn_up_raw, btn_down_raw, btn_left_raw, btn_right_raw  in  1 each  raw asynchronous button levels, active-high
- pulse_up, pulse_down, pulse_left, pulse_right  out  1 each  registered one-cycle press pulses, consumed by the detector's button inputs
- held  out  1  registered; 1 while the FSM is in HELD

## Operation
- Per channel: optional 2-FF synchronizer (see Configuration), then debounce: stable level `s`, counter `cnt`.
  - Input == s → cnt <= 0.
  - Input != s and cnt == DB_CYCLES-1 → s <= input, cnt <= 0.
  - Otherwise → cnt <= cnt+1.
  - Any single-cycle glitch resets the count. Counter never wraps.
- Lockout FSM, 2 states:
  - IDLE: if any stable level is 1 → assert exactly one pulse for the highest-priority high channel (up > down > left > right) → HELD. Else stay.
  - HELD: no pulses. When all four stable levels are 0 → IDLE.
- Simultaneous presses: one pulse only, by priority. Second button pressed while first held: no pulse.
- A release bounce is absorbed by debounce. A re-press before every button is stable-low gives no pulse.
- Pulses are mutually exclusive and never high two consecutive cycles.

## Timing
- Reset: sync FFs, s, cnt = 0; FSM = IDLE; all pulse_* = 0; held = 0. Reset mid-count discards the partial count. A button held through reset release is treated as a new press once debounced.
- Latency: edge E0 is the first rising edge sampling raw = 1, with raw held stable.
  - With sync: s rises at edge E0+DB_CYCLES+1; pulse is high for the one cycle after edge E0+DB_CYCLES+2; held rises at the same edge.
  - Without sync: both latencies are 2 less.
- Release: held falls 1 edge after the last stable level falls.

## Configuration
- BUTTON_PULSE_SYNC_EN defined: 2-FF synchronizer per channel (default build).
- BUTTON_PULSE_SYNC_EN undefined: raw inputs feed debounce directly; latency reduced by 2 cycles. For simulation and synchronous-stimulus builds only.

## Structure
- Shared package `button_pkg`:
  - FSM state typedef (IDLE, HELD).
  - Channel index constants BTN_UP=0, BTN_DOWN=1, BTN_LEFT=2, BTN_RIGHT=3 (priority order).
  - Default DB_CYCLES.
- Sub-module `debounce_ch`: synchronizer + counter + stable level for one channel, instantiated 4×. Top holds the FSM, priority encode and output registers.

## Test plan
All scenarios use DB_CYCLES=4 with sync enabled.
- Clean press: up held 20 cycles → pulse_up high exactly 1 cycle, at edge E0+6. held rises with the pulse and falls 7 edges after release (6 to debounce, 1 for the FSM).
- Bounce: down toggles 1,0,1,0 each cycle, then held steady 10 cycles → exactly one pulse_down, 6 edges after the steady-high start.
- Glitch: left high for 3 cycles then low → no pulse; held stays 0.
- Simultaneous: right and left rise same cycle → single pulse_left, no pulse_right. Release both, then press right → pulse_right.
- Overlap: up held, then down pressed while up held, then both released → only pulse_up. Down pressed again after release → pulse_down.
- Reset mid-press: reset asserted 1 cycle at cnt=2 while up held → outputs 0. pulse_up then occurs 6 edges after reset deasserts.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and constants for the button conditioning stage.
// Channel indices double as priority order (lowest index wins).
package button_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } lock_state_t;

  localparam int NUM_BTN       = 4;
  localparam int BTN_UP        = 0;
  localparam int BTN_DOWN      = 1;
  localparam int BTN_LEFT      = 2;
  localparam int BTN_RIGHT     = 3;
  localparam int DEF_DB_CYCLES = 500000;

  // One-hot of the lowest-index set bit, zero when nothing is set.
  function automatic logic [NUM_BTN-1:0] pick_first(input logic [NUM_BTN-1:0] lv);
    logic [NUM_BTN-1:0] oh;
    oh = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (lv[i]) oh = NUM_BTN'(1) << i;
    end
    return oh;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One button channel: optional 2-FF synchronizer (BUTTON_PULSE_SYNC_EN), then debounce counter.
// Latency: stable follows a steady input after DB_CYCLES (+2 with sync) edges; no backpressure.
module debounce_ch
  import button_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  logic             din;
  logic [CNT_W-1:0] cnt;

`ifdef BUTTON_PULSE_SYNC_EN
  logic sync_q1;
  logic sync_q2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  assign din = sync_q2;
`else
  assign din = raw;
`endif

  // Any cycle matching the stable level restarts the count, so glitches never accumulate.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (din == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
      stable <= din;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/button_pulse.sv
// Debounced one-shot press pulses for four buttons with press lockout (sync via BUTTON_PULSE_SYNC_EN).
// Latency: pulse one edge after the stable level rises; no backpressure, pulses are fire-and-forget.
module button_pulse
  import button_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up_raw,
  input  logic btn_down_raw,
  input  logic btn_left_raw,
  input  logic btn_right_raw,
  output logic pulse_up,
  output logic pulse_down,
  output logic pulse_left,
  output logic pulse_right,
  output logic held
);

  logic [NUM_BTN-1:0] raw_vec;
  logic [NUM_BTN-1:0] stable;
  logic [NUM_BTN-1:0] pulse_d;
  logic [NUM_BTN-1:0] pulse_q;
  lock_state_t        state_q;
  lock_state_t        state_d;

  assign raw_vec[BTN_UP]    = btn_up_raw;
  assign raw_vec[BTN_DOWN]  = btn_down_raw;
  assign raw_vec[BTN_LEFT]  = btn_left_raw;
  assign raw_vec[BTN_RIGHT] = btn_right_raw;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    debounce_ch #(
      .DB_CYCLES(DB_CYCLES),
      .CNT_W    (CNT_W)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_vec[i]),
      .stable(stable[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Stay locked until every button is stable-low, so a held or added button never re-fires.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (|stable)  state_d = HELD;
      HELD: if (~|stable) state_d = IDLE;
    endcase
  end

  always_comb begin
    pulse_d = '0;
    if (state_q == IDLE) pulse_d = pick_first(stable);
  end

  always_ff @(posedge clk) begin
    if (reset) pulse_q <= '0;
    else       pulse_q <= pulse_d;
  end

  assign pulse_up    = pulse_q[BTN_UP];
  assign pulse_down  = pulse_q[BTN_DOWN];
  assign pulse_left  = pulse_q[BTN_LEFT];
  assign pulse_right = pulse_q[BTN_RIGHT];
  assign held        = (state_q == HELD);

endmodule

// File: tb/tb_button_pulse.sv
// Directed bench for button_pulse with DB_CYCLES=4; latencies adapt to BUTTON_PULSE_SYNC_EN.
module tb_button_pulse;

  localparam int DB = 4;
`ifdef BUTTON_PULSE_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  // Edges from the first sample of a steady input to the FSM edge that fires the pulse.
  localparam int L = DB + SYNC_LAT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic pulse_up, pulse_down, pulse_left, pulse_right, held;

  int tests = 0;
  int fails = 0;
  int tk = 0;
  int n_up, n_down, n_left, n_right, n_hrise;
  int t_up, t_down, t_left, t_right, t_hrise, t_hfall;
  int viol = 0;
  logic prev_any = 1'b0;
  logic prev_held = 1'b0;

  always #5 clk = ~clk;

  button_pulse #(.DB_CYCLES(DB)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_up_raw   (up),
    .btn_down_raw (down),
    .btn_left_raw (left),
    .btn_right_raw(right),
    .pulse_up     (pulse_up),
    .pulse_down   (pulse_down),
    .pulse_left   (pulse_left),
    .pulse_right  (pulse_right),
    .held         (held)
  );

  task automatic clear_mon();
    n_up = 0; n_down = 0; n_left = 0; n_right = 0; n_hrise = 0;
    t_up = -1; t_down = -1; t_left = -1; t_right = -1; t_hrise = -1; t_hfall = -1;
  endtask

  // Advance one edge, then sample outputs 1 time unit later and log pulse/held events.
  task automatic tick();
    logic [3:0] p;
    @(posedge clk);
    #1;
    tk++;
    p = {pulse_right, pulse_left, pulse_down, pulse_up};
    if ($countones(p) > 1) viol++;
    if (prev_any && (p != 4'b0)) viol++;
    prev_any = (p != 4'b0);
    if (pulse_up)    begin n_up++;    t_up = tk;    end
    if (pulse_down)  begin n_down++;  t_down = tk;  end
    if (pulse_left)  begin n_left++;  t_left = tk;  end
    if (pulse_right) begin n_right++; t_right = tk; end
    if (held && !prev_held) begin n_hrise++; t_hrise = tk; end
    if (!held && prev_held) t_hfall = tk;
    prev_held = held;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    run(3);
    tests++;
    if ({pulse_up, pulse_down, pulse_left, pulse_right} !== 4'b0) begin
      $display("FAIL reset_pulses got %b want 0000", {pulse_up, pulse_down, pulse_left, pulse_right});
      fails++;
    end
    tests++;
    if (held !== 1'b0) begin
      $display("FAIL reset_held got %b want 0", held);
      fails++;
    end
    reset = 1'b0;
    run(2);
  endtask

  task automatic test_clean_press();
    int t0, t1;
    clear_mon();
    up = 1'b1; t0 = tk;
    run(20);
    up = 1'b0; t1 = tk;
    run(20);
    tests++;
    if (n_up !== 1) begin $display("FAIL clean_count got %0d want 1", n_up); fails++; end
    tests++;
    if (t_up !== t0 + L + 1) begin $display("FAIL clean_latency got %0d want %0d", t_up, t0 + L + 1); fails++; end
    tests++;
    if (t_hrise !== t0 + L + 1) begin $display("FAIL clean_held_rise got %0d want %0d", t_hrise, t0 + L + 1); fails++; end
    tests++;
    if (t_hfall !== t1 + L + 1) begin $display("FAIL clean_held_fall got %0d want %0d", t_hfall, t1 + L + 1); fails++; end
  endtask

  task automatic test_bounce();
    int t0;
    clear_mon();
    down = 1'b1; tick();
    down = 1'b0; tick();
    down = 1'b1; tick();
    down = 1'b0; tick();
    down = 1'b1; t0 = tk;
    run(14);
    down = 1'b0;
    run(20);
    tests++;
    if (n_down !== 1) begin $display("FAIL bounce_count got %0d want 1", n_down); fails++; end
    tests++;
    if (t_down !== t0 + L + 1) begin $display("FAIL bounce_latency got %0d want %0d", t_down, t0 + L + 1); fails++; end
  endtask

  task automatic test_glitch();
    clear_mon();
    left = 1'b1;
    run(3);
    left = 1'b0;
    run(15);
    tests++;
    if (n_left !== 0) begin $display("FAIL glitch_count got %0d want 0", n_left); fails++; end
    tests++;
    if (n_hrise !== 0) begin $display("FAIL glitch_held got %0d rises want 0", n_hrise); fails++; end
  endtask

  task automatic test_simultaneous();
    int t0;
    clear_mon();
    left = 1'b1; right = 1'b1; t0 = tk;
    run(15);
    left = 1'b0; right = 1'b0;
    run(20);
    tests++;
    if (n_left !== 1) begin $display("FAIL simul_left got %0d want 1", n_left); fails++; end
    tests++;
    if (n_right !== 0) begin $display("FAIL simul_right got %0d want 0", n_right); fails++; end
    tests++;
    if (t_left !== t0 + L + 1) begin $display("FAIL simul_latency got %0d want %0d", t_left, t0 + L + 1); fails++; end
    clear_mon();
    right = 1'b1;
    run(15);
    right = 1'b0;
    run(20);
    tests++;
    if (n_right !== 1) begin $display("FAIL simul_right_alone got %0d want 1", n_right); fails++; end
  endtask

  task automatic test_overlap();
    clear_mon();
    up = 1'b1;
    run(12);
    down = 1'b1;
    run(12);
    up = 1'b0; down = 1'b0;
    run(20);
    tests++;
    if (n_up !== 1) begin $display("FAIL overlap_up got %0d want 1", n_up); fails++; end
    tests++;
    if (n_down !== 0) begin $display("FAIL overlap_down got %0d want 0", n_down); fails++; end
    clear_mon();
    down = 1'b1;
    run(15);
    down = 1'b0;
    run(20);
    tests++;
    if (n_down !== 1) begin $display("FAIL overlap_repress got %0d want 1", n_down); fails++; end
  endtask

  task automatic test_reset_mid_press();
    int tr;
    clear_mon();
    up = 1'b1;
    // Leaves the debounce counter at 2.
    run(SYNC_LAT + 2);
    reset = 1'b1;
    tick();
    reset = 1'b0; tr = tk;
    tests++;
    if ({pulse_up, held} !== 2'b00) begin
      $display("FAIL midreset_outputs got %b want 00", {pulse_up, held});
      fails++;
    end
    run(15);
    up = 1'b0;
    run(20);
    tests++;
    if (n_up !== 1) begin $display("FAIL midreset_count got %0d want 1", n_up); fails++; end
    tests++;
    if (t_up !== tr + L + 1) begin $display("FAIL midreset_latency got %0d want %0d", t_up, tr + L + 1); fails++; end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_overlap();
    test_reset_mid_press();
    tests++;
    if (viol !== 0) begin $display("FAIL pulse_exclusive got %0d violations want 0", viol); fails++; end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
